vga_scanout: RTL
================

Name: vga_scanout

Overview:
- FIFO consumer and video timing generator for the 640x480 display path.
- Pops 16-bit RGB565 pixels from the scanline FIFO that the line renderer fills.
- Generates VGA horizontal and vertical sync and blanking.
- Issues the one-cycle frame trigger that starts rendering, plus a FIFO clear.
- Sits between the pixel FIFO and the DAC/pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PRELOAD_LINES, 2, lines before line 0 at which trigger fires
- UNDERFLOW_COLOR, 16'h0000, pixel driven when FIFO is empty in the active area

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_ce  in  1  pixel clock enable; counters and pixel pipeline advance only when high
- fifo_data  in  16  FIFO head word, FWFT, valid while fifo_empty=0
- fifo_empty  in  1  FIFO empty
- fifo_read  out  1  pop FIFO head this cycle
- fifo_clear  out  1  flush FIFO, one-cycle pulse
- trigger  out  1  start-of-frame pulse to renderer, one clk cycle
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_r  out  5  red
- vga_g  out  6  green
- vga_b  out  5  blue
- blank  out  1  high outside the visible area
- underflow  out  1  sticky: FIFO was empty during the active area this frame

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - hc=0, vc=0.
  - vga_hsync=1, vga_vsync=1, blank=1, rgb=0.
  - trigger=0, fifo_clear=0, underflow=0.
  - fifo_read=0 is forced combinationally while rst_n=0.
  - Reset mid-frame restarts timing at hc=0, vc=0.
- Counters:
  - hc runs 0..H_TOTAL-1, with H_TOTAL=800.
  - vc runs 0..V_TOTAL-1, with V_TOTAL=525.
  - Both advance only when pix_ce=1. hc wraps to 0; vc increments on hc wrap and wraps to 0 at V_TOTAL-1.
  - Both counters are 10 bits.
- Phase decode:
  - Horizontal: ACTIVE hc<640, FRONT 640..655, SYNC 656..751, BACK 752..799.
  - Vertical: same scheme on vc.
  - active = h ACTIVE and v ACTIVE.
- fifo_read = pix_ce & active & !fifo_empty & rst_n. This is combinational and never asserted when the FIFO is empty.
- Pixel register, updated on pix_ce:
  - If active and !fifo_empty: rgb <= fifo_data, split as {r[15:11], g[10:5], b[4:0]}.
  - Else if active and fifo_empty: rgb <= UNDERFLOW_COLOR and underflow <= 1.
  - Else: rgb <= 0.
- Sync and blank registered on pix_ce from the same counter values:
  - vga_hsync = !(h SYNC).
  - vga_vsync = !(v SYNC).
  - blank = !active.
- Latency: all video outputs appear 1 pix_ce-cycle after the counter value that produced them, aligned with each other.
- trigger and fifo_clear:
  - Pulse high for exactly one clk cycle, on the pix_ce cycle where vc == V_TOTAL-PRELOAD_LINES (523) and hc == 0.
  - Never fire on a cycle with pix_ce=0.
  - The same cycle clears underflow, so underflow covers exactly one frame.
  - If simultaneous with a FIFO write from the renderer, clear takes precedence (FIFO-side responsibility).
- Underflow recovery:
  - Pixels are not skipped: the next available word is shown at the next active position, so the frame is corrupted until the next trigger.
  - The next trigger/fifo_clear realigns.
- pix_ce=0: all outputs and counters hold; fifo_read=0.
- First frame after reset: no trigger until vc reaches 523, so the FIFO is empty and the first frame shows UNDERFLOW_COLOR with underflow=1. This is accepted.

Decomposition:
- Package vga16_pkg:
  - 640x480@60 timing constants: H_*, V_*, H_TOTAL, V_TOTAL.
  - typedef rgb565_t, a packed struct {r[4:0], g[5:0], b[4:0]}.
  - Shared with the line renderer.
- Sub-module vga_timing:
  - Contents: hc/vc counters, phase decode, active, and the trigger/sync generation.
  - vga_scanout instantiates it and adds the FIFO handshake, pixel register and underflow flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with pix_ce=1 -> hsync=1, vsync=1, blank=1, rgb=0, trigger=0, fifo_read=0; first pix_ce after release has hc=0, vc=0.
- Timing (pix_ce=1, FIFO model always full):
  - vga_hsync low for exactly 96 cycles, starting 657 cycles after line start; period 800.
  - vga_vsync low for 2 lines, starting at vc=490(+1 cycle latency); frame period 420000 cycles.
- Trigger:
  - Exactly one trigger and one fifo_clear per frame, at vc=523, hc=0.
  - With pix_ce toggling every other cycle, the pulse is still 1 clk wide.
- Data path:
  - FIFO preloaded with 640 words: word 0 = 16'hF800, others = 16'h07E0.
  - Line 0, pixel 0 shows r=31, g=0, b=0; pixel 1 shows r=0, g=63, b=0.
  - fifo_read is asserted 640 times per line and never during blank.
- Underflow:
  - FIFO empties at hc=100 of line 5 -> rgb=0, underflow=1, fifo_read=0 while empty.
  - underflow clears at the next trigger.
- Stall: pix_ce=0 for 50 cycles mid-line -> hc, vc, rgb and sync hold; fifo_read=0; no FIFO words consumed.

Source files
------------

// File: rtl/vga16_pkg.sv
// rtl/vga16_pkg.sv - 640x480@60 timing constants and RGB565 types shared by scanout and renderer.
package vga16_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int          PRELOAD_LINES   = 2;
  localparam logic [15:0] UNDERFLOW_COLOR = 16'h0000;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // Boundaries are exclusive upper limits of each phase along one axis.
  function automatic phase_t decode_phase(
    input logic [9:0] cnt,
    input logic [9:0] active_end,
    input logic [9:0] sync_start,
    input logic [9:0] sync_end
  );
    if (cnt < active_end)      return PH_ACTIVE;
    else if (cnt < sync_start) return PH_FRONT;
    else if (cnt < sync_end)   return PH_SYNC;
    else                       return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - FWFT scanline FIFO port between the pixel FIFO and the scanout.
interface vga_scanout_if;

  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        fifo_clear;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read,
    output fifo_clear
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_read,
    input  fifo_clear
  );

endinterface

// File: rtl/vga_scanout_timing.sv
// rtl/vga_scanout_timing.sv - hc/vc counters, phase decode, registered sync/blank and frame trigger.
module vga_timing #(
  parameter int H_ACTIVE      = vga16_pkg::H_ACTIVE,
  parameter int H_FP          = vga16_pkg::H_FP,
  parameter int H_SYNC        = vga16_pkg::H_SYNC,
  parameter int H_BP          = vga16_pkg::H_BP,
  parameter int V_ACTIVE      = vga16_pkg::V_ACTIVE,
  parameter int V_FP          = vga16_pkg::V_FP,
  parameter int V_SYNC        = vga16_pkg::V_SYNC,
  parameter int V_BP          = vga16_pkg::V_BP,
  parameter int PRELOAD_LINES = vga16_pkg::PRELOAD_LINES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_ce,
  output logic active,
  output logic trigger,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic blank
);
  import vga16_pkg::*;

  localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_PERIOD - 1);
  localparam logic [9:0] V_LAST       = 10'(V_PERIOD - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] TRIG_LINE    = 10'(V_PERIOD - PRELOAD_LINES);

  logic [9:0] hc;
  logic [9:0] vc;
  phase_t     h_phase;
  phase_t     v_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  always_comb begin
    h_phase = decode_phase(hc, H_ACT_END, H_SYNC_START, H_SYNC_END);
    v_phase = decode_phase(vc, V_ACT_END, V_SYNC_START, V_SYNC_END);
    active  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  end

  // Combinational so the pulse is exactly the one clk cycle that carries the pix_ce.
  assign trigger = rst_n & pix_ce & (vc == TRIG_LINE) & (hc == 10'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      blank     <= 1'b1;
    end else if (pix_ce) begin
      vga_hsync <= (h_phase != PH_SYNC);
      vga_vsync <= (v_phase != PH_SYNC);
      blank     <= !active;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - scanline FIFO consumer: pops RGB565 pixels in the active area and drives VGA pins.
module vga_scanout #(
  parameter int          H_ACTIVE        = vga16_pkg::H_ACTIVE,
  parameter int          H_FP            = vga16_pkg::H_FP,
  parameter int          H_SYNC          = vga16_pkg::H_SYNC,
  parameter int          H_BP            = vga16_pkg::H_BP,
  parameter int          V_ACTIVE        = vga16_pkg::V_ACTIVE,
  parameter int          V_FP            = vga16_pkg::V_FP,
  parameter int          V_SYNC          = vga16_pkg::V_SYNC,
  parameter int          V_BP            = vga16_pkg::V_BP,
  parameter int          PRELOAD_LINES   = vga16_pkg::PRELOAD_LINES,
  parameter logic [15:0] UNDERFLOW_COLOR = vga16_pkg::UNDERFLOW_COLOR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_ce,
  vga_scanout_if.master        fifo,
  output logic                 trigger,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [4:0]           vga_r,
  output logic [5:0]           vga_g,
  output logic [4:0]           vga_b,
  output logic                 blank,
  output logic                 underflow
);
  import vga16_pkg::*;

  logic    active;
  rgb565_t pix_q;

  vga_timing #(
    .H_ACTIVE      (H_ACTIVE),
    .H_FP          (H_FP),
    .H_SYNC        (H_SYNC),
    .H_BP          (H_BP),
    .V_ACTIVE      (V_ACTIVE),
    .V_FP          (V_FP),
    .V_SYNC        (V_SYNC),
    .V_BP          (V_BP),
    .PRELOAD_LINES (PRELOAD_LINES)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_ce    (pix_ce),
    .active    (active),
    .trigger   (trigger),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .blank     (blank)
  );

  assign fifo.fifo_read  = pix_ce & active & ~fifo.fifo_empty & rst_n;
  assign fifo.fifo_clear = trigger;

  // An empty FIFO does not skip pixels: the next word lands on the next active slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q     <= '0;
      underflow <= 1'b0;
    end else if (pix_ce) begin
      if (active && !fifo.fifo_empty) begin
        pix_q <= rgb565_t'(fifo.fifo_data);
      end else if (active) begin
        pix_q     <= rgb565_t'(UNDERFLOW_COLOR);
        underflow <= 1'b1;
      end else begin
        pix_q <= '0;
        if (trigger) underflow <= 1'b0;
      end
    end
  end

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;

endmodule
